// File: rtl/smac_seq_ctrl.sv
// Sequencer for a bit-serial MAC array: walks weight/activation bit planes per op, filter group and position.
// Latency: LOAD one cycle after start is accepted; strobes are registered and show in the cycle of their state.
// Backpressure: stall freezes every register and masks all strobes in the same cycle; busy stays high.
module smac_seq_ctrl #(
    parameter int PA_MAX  = 8,
    parameter int PW_MAX  = 8,
    parameter int MNO     = 288,
    parameter int MNV     = 50176,
    parameter int NFG_MAX = 8,
    localparam int OPW    = $clog2(MNO + 1),
    localparam int FILW   = $clog2(NFG_MAX + 1),
    localparam int VOLW   = $clog2(MNV + 1),
    localparam int FIW    = (NFG_MAX > 1) ? $clog2(NFG_MAX) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stall,
    input  logic            cfg_pa_sel,
    input  logic [1:0]      cfg_pw_sel,
    input  logic [OPW-1:0]  cfg_num_ops,
    input  logic [FILW-1:0] cfg_num_fil,
    input  logic [VOLW-1:0] cfg_num_vol,
    input  logic            cfg_cont,
    output logic            busy,
    output logic            act_load,
    output logic            wei_load,
    output logic            acc_clr,
    output logic            acc_en,
    output logic            msb_a,
    output logic            msb_w,
    output logic            quant_en,
    output logic            wb,
    output logic            update_in,
    output logic            update_out,
    output logic            done,
    output logic [2:0]      bit_a_idx,
    output logic [2:0]      bit_w_idx,
    output logic [FIW-1:0]  fil_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_QUANT,
        S_WB,
        S_UPDATE
    } state_t;

    // Precisions are held as the index of their last bit (Pa-1, Pw-1).
    typedef struct packed {
        logic [2:0]      pa_last;
        logic [2:0]      pw_last;
        logic [OPW-1:0]  num_ops;
        logic [FILW-1:0] num_fil;
        logic [VOLW-1:0] num_vol;
        logic            cont;
    } cfg_t;

    state_t          state;
    cfg_t            cfg_q;
    cfg_t            cfg_in;
    logic [OPW-1:0]  op_cnt;
    logic [VOLW-1:0] vol_cnt;
    logic [FIW-1:0]  fil_q;
    logic [2:0]      bit_a_q;
    logic [2:0]      bit_w_q;
    logic [2:0]      bit_a_nxt;
    logic [2:0]      bit_w_nxt;
    logic            w_wrap;
    logic            a_wrap;
    logic            op_last;
    logic            fil_last;
    logic            vol_last;
    logic            frozen;
    logic            busy_q;
    logic            act_load_q;
    logic            wei_load_q;
    logic            acc_clr_q;
    logic            acc_en_q;
    logic            msb_a_q;
    logic            msb_w_q;
    logic            quant_en_q;
    logic            wb_q;
    logic            update_in_q;
    logic            update_out_q;
    logic            done_q;

    // Selects beyond the synthesised maximum precision clamp to that maximum.
    always_comb begin
        cfg_in.pa_last = (cfg_pa_sel && (PA_MAX >= 8)) ? 3'd7 : 3'd3;
        if ((cfg_pw_sel == 2'b00) || (PW_MAX < 4)) begin
            cfg_in.pw_last = 3'd1;
        end else if ((cfg_pw_sel == 2'b01) || (PW_MAX < 8)) begin
            cfg_in.pw_last = 3'd3;
        end else begin
            cfg_in.pw_last = 3'd7;
        end
        cfg_in.num_ops = (cfg_num_ops == '0) ? OPW'(1)  : cfg_num_ops;
        cfg_in.num_fil = (cfg_num_fil == '0) ? FILW'(1) : cfg_num_fil;
        cfg_in.num_vol = (cfg_num_vol == '0) ? VOLW'(1) : cfg_num_vol;
        cfg_in.cont    = cfg_cont;
    end

    always_comb begin
        w_wrap    = (bit_w_q == cfg_q.pw_last);
        a_wrap    = (bit_a_q == cfg_q.pa_last);
        bit_w_nxt = w_wrap ? 3'd0 : bit_w_q + 3'd1;
        bit_a_nxt = w_wrap ? (a_wrap ? 3'd0 : bit_a_q + 3'd1) : bit_a_q;
        op_last   = ((op_cnt + OPW'(1)) >= cfg_q.num_ops);
        fil_last  = ((FILW'(fil_q) + FILW'(1)) >= cfg_q.num_fil);
        vol_last  = ((vol_cnt + VOLW'(1)) >= cfg_q.num_vol);
        frozen    = stall && (state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cfg_q        <= '0;
            op_cnt       <= '0;
            vol_cnt      <= '0;
            fil_q        <= '0;
            bit_a_q      <= '0;
            bit_w_q      <= '0;
            busy_q       <= 1'b0;
            act_load_q   <= 1'b0;
            wei_load_q   <= 1'b0;
            acc_clr_q    <= 1'b0;
            acc_en_q     <= 1'b0;
            msb_a_q      <= 1'b0;
            msb_w_q      <= 1'b0;
            quant_en_q   <= 1'b0;
            wb_q         <= 1'b0;
            update_in_q  <= 1'b0;
            update_out_q <= 1'b0;
            done_q       <= 1'b0;
        end else if (!frozen) begin
            act_load_q   <= 1'b0;
            wei_load_q   <= 1'b0;
            acc_clr_q    <= 1'b0;
            acc_en_q     <= 1'b0;
            msb_a_q      <= 1'b0;
            msb_w_q      <= 1'b0;
            quant_en_q   <= 1'b0;
            wb_q         <= 1'b0;
            update_in_q  <= 1'b0;
            update_out_q <= 1'b0;
            done_q       <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        cfg_q      <= cfg_in;
                        state      <= S_LOAD;
                        busy_q     <= 1'b1;
                        wei_load_q <= 1'b1;
                        act_load_q <= 1'b1;
                        acc_clr_q  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    // Bit indices are always 0 here, so the first COMPUTE cycle is plane (0,0).
                    state    <= S_COMPUTE;
                    acc_en_q <= 1'b1;
                    msb_w_q  <= (bit_w_q == cfg_q.pw_last);
                    msb_a_q  <= (bit_a_q == cfg_q.pa_last);
                end
                S_COMPUTE: begin
                    if (w_wrap && a_wrap) begin
                        bit_a_q <= 3'd0;
                        bit_w_q <= 3'd0;
                        if (op_last) begin
                            op_cnt     <= '0;
                            state      <= S_QUANT;
                            quant_en_q <= 1'b1;
                        end else begin
                            op_cnt     <= op_cnt + OPW'(1);
                            state      <= S_LOAD;
                            wei_load_q <= 1'b1;
                            act_load_q <= (fil_q == '0);
                        end
                    end else begin
                        bit_w_q  <= bit_w_nxt;
                        bit_a_q  <= bit_a_nxt;
                        acc_en_q <= 1'b1;
                        msb_w_q  <= (bit_w_nxt == cfg_q.pw_last);
                        msb_a_q  <= (bit_a_nxt == cfg_q.pa_last);
                    end
                end
                S_QUANT: begin
                    state        <= S_WB;
                    wb_q         <= 1'b1;
                    update_out_q <= 1'b1;
                end
                S_WB: begin
                    if (!fil_last) begin
                        fil_q      <= fil_q + FIW'(1);
                        state      <= S_LOAD;
                        wei_load_q <= 1'b1;
                        acc_clr_q  <= 1'b1;
                    end else begin
                        fil_q       <= '0;
                        state       <= S_UPDATE;
                        done_q      <= vol_last;
                        update_in_q <= !vol_last;
                    end
                end
                S_UPDATE: begin
                    if (vol_last) begin
                        vol_cnt <= '0;
                        op_cnt  <= '0;
                        fil_q   <= '0;
                        bit_a_q <= 3'd0;
                        bit_w_q <= 3'd0;
                        if (cfg_q.cont) begin
                            cfg_q      <= cfg_in;
                            state      <= S_LOAD;
                            wei_load_q <= 1'b1;
                            act_load_q <= 1'b1;
                            acc_clr_q  <= 1'b1;
                        end else begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        vol_cnt    <= vol_cnt + VOLW'(1);
                        state      <= S_LOAD;
                        wei_load_q <= 1'b1;
                        act_load_q <= 1'b1;
                        acc_clr_q  <= 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign act_load   = act_load_q   & ~stall;
    assign wei_load   = wei_load_q   & ~stall;
    assign acc_clr    = acc_clr_q    & ~stall;
    assign acc_en     = acc_en_q     & ~stall;
    assign msb_a      = msb_a_q      & ~stall;
    assign msb_w      = msb_w_q      & ~stall;
    assign quant_en   = quant_en_q   & ~stall;
    assign wb         = wb_q         & ~stall;
    assign update_in  = update_in_q  & ~stall;
    assign update_out = update_out_q & ~stall;
    assign done       = done_q       & ~stall;
    assign bit_a_idx  = bit_a_q;
    assign bit_w_idx  = bit_w_q;
    assign fil_idx    = fil_q;

endmodule

// File: tb/tb_smac_seq_ctrl.sv
// Directed bench for smac_seq_ctrl: hand-computed cycle positions, pulse counts and totals per run.
module tb_smac_seq_ctrl;

    localparam int OPW  = 9;
    localparam int FILW = 4;
    localparam int VOLW = 16;
    localparam int FIW  = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            stall;
    logic            cfg_pa_sel;
    logic [1:0]      cfg_pw_sel;
    logic [OPW-1:0]  cfg_num_ops;
    logic [FILW-1:0] cfg_num_fil;
    logic [VOLW-1:0] cfg_num_vol;
    logic            cfg_cont;
    logic            busy, act_load, wei_load, acc_clr, acc_en, msb_a, msb_w;
    logic            quant_en, wb, update_in, update_out, done;
    logic [2:0]      bit_a_idx, bit_w_idx;
    logic [FIW-1:0]  fil_idx;

    logic [10:0] strb;
    logic [20:0] all_out;
    assign strb    = {act_load, wei_load, acc_clr, acc_en, msb_a, msb_w, quant_en, wb, update_in, update_out, done};
    assign all_out = {busy, strb, bit_a_idx, bit_w_idx, fil_idx};

    smac_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .cfg_pa_sel(cfg_pa_sel), .cfg_pw_sel(cfg_pw_sel), .cfg_num_ops(cfg_num_ops),
        .cfg_num_fil(cfg_num_fil), .cfg_num_vol(cfg_num_vol), .cfg_cont(cfg_cont),
        .busy(busy), .act_load(act_load), .wei_load(wei_load), .acc_clr(acc_clr),
        .acc_en(acc_en), .msb_a(msb_a), .msb_w(msb_w), .quant_en(quant_en), .wb(wb),
        .update_in(update_in), .update_out(update_out), .done(done),
        .bit_a_idx(bit_a_idx), .bit_w_idx(bit_w_idx), .fil_idx(fil_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int busy_cyc, wei_cnt, act_cnt, act_err, clr_cnt, acc_cnt, first_acc, last_acc;
    int first_load, second_load, quant_cyc, wb_cyc, upd_out_cnt, upd_in_cnt;
    int done_cnt, done_cyc, idx_err, msb_err, stall_err, load_after_done;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pa_last_of(input logic sel);
        return sel ? 7 : 3;
    endfunction

    function automatic int pw_last_of(input logic [1:0] sel);
        return (sel == 2'b00) ? 1 : ((sel == 2'b01) ? 3 : 7);
    endfunction

    // One run from start (cycle 0) until busy drops; alt cfg is driven from cycle 1 on.
    task automatic do_run(input logic pa, input logic [1:0] pw, input int ops, input int fil,
                          input int vol, input logic cont, input logic a_pa, input logic [1:0] a_pw,
                          input int a_ops, input int a_fil, input int a_vol, input logic a_cont,
                          input int stall_at, input int stall_len, input bit hold_start);
        int pal, pwl, ea, ew;
        bit finished;
        busy_cyc = 0; wei_cnt = 0; act_cnt = 0; act_err = 0; clr_cnt = 0; acc_cnt = 0;
        first_acc = 0; last_acc = 0; first_load = 0; second_load = 0; quant_cyc = 0; wb_cyc = 0;
        upd_out_cnt = 0; upd_in_cnt = 0; done_cnt = 0; done_cyc = 0; idx_err = 0; msb_err = 0;
        stall_err = 0; load_after_done = 0;
        pal = pa_last_of(pa); pwl = pw_last_of(pw); ea = 0; ew = 0; finished = 0;
        @(posedge clk); #1;
        start = 1'b1; stall = 1'b0;
        cfg_pa_sel = pa; cfg_pw_sel = pw; cfg_num_ops = OPW'(ops);
        cfg_num_fil = FILW'(fil); cfg_num_vol = VOLW'(vol); cfg_cont = cont;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk); #1;
            start = hold_start && (done_cnt == 0);
            cfg_pa_sel = a_pa; cfg_pw_sel = a_pw; cfg_num_ops = OPW'(a_ops);
            cfg_num_fil = FILW'(a_fil); cfg_num_vol = VOLW'(a_vol); cfg_cont = a_cont;
            stall = (c >= stall_at) && (c < stall_at + stall_len);
            @(negedge clk);
            if (!busy) begin
                finished = 1;
                break;
            end
            busy_cyc++;
            if (stall && (strb != '0)) stall_err++;
            if (wei_load) begin
                wei_cnt++;
                if (first_load == 0) first_load = c;
                else if (second_load == 0) second_load = c;
                if (done_cnt > 0 && c == done_cyc + 1) load_after_done = 1;
            end
            if (act_load) begin
                act_cnt++;
                if (fil_idx != '0) act_err++;
            end
            if (acc_clr) clr_cnt++;
            if (acc_en) begin
                acc_cnt++;
                if (first_acc == 0) first_acc = c;
                last_acc = c;
                if (int'(bit_a_idx) != ea || int'(bit_w_idx) != ew) idx_err++;
                if (msb_w != (int'(bit_w_idx) == pwl) || msb_a != (int'(bit_a_idx) == pal)) msb_err++;
                if (ew == pwl) begin
                    ew = 0;
                    ea = (ea == pal) ? 0 : ea + 1;
                end else begin
                    ew++;
                end
            end else if (msb_a || msb_w) begin
                msb_err++;
            end
            if (quant_en) quant_cyc = c;
            if (wb) wb_cyc = c;
            if (update_out) upd_out_cnt++;
            if (update_in) upd_in_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = c;
                pal = pa_last_of(a_pa); pwl = pw_last_of(a_pw); ea = 0; ew = 0;
            end
        end
        if (!finished) check_eq("run_timeout", 0, 1);
        start = 1'b0; stall = 1'b0;
    endtask

    logic        sw_pa [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [1:0]  sw_pw [7] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};
    int          sw_len[7] = '{8, 16, 32, 16, 32, 64, 64};

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; stall = 1'b0; cfg_pa_sel = 1'b0; cfg_pw_sel = 2'd0;
        cfg_num_ops = '0; cfg_num_fil = '0; cfg_num_vol = '0; cfg_cont = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outputs", int'(all_out), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single run, Pa=4 Pw=2 ops=2.
        do_run(1'b0, 2'd0, 2, 1, 1, 1'b0, 1'b0, 2'd0, 2, 1, 1, 1'b0, 0, 0, 0);
        check_eq("single_load1", first_load, 1);
        check_eq("single_load2", second_load, 10);
        check_eq("single_acc_first", first_acc, 2);
        check_eq("single_acc_last", last_acc, 18);
        check_eq("single_acc_cnt", acc_cnt, 16);
        check_eq("single_clr_cnt", clr_cnt, 1);
        check_eq("single_quant", quant_cyc, 19);
        check_eq("single_wb", wb_cyc, 20);
        check_eq("single_done", done_cyc, 21);
        check_eq("single_busy", busy_cyc, 21);
        check_eq("single_idx_err", idx_err, 0);

        // Precision sweep with ops=1.
        for (int i = 0; i < 7; i++) begin
            do_run(sw_pa[i], sw_pw[i], 1, 1, 1, 1'b0, sw_pa[i], sw_pw[i], 1, 1, 1, 1'b0, 0, 0, 0);
            check_eq($sformatf("sweep%0d_compute", i), acc_cnt, sw_len[i]);
            check_eq($sformatf("sweep%0d_total", i), busy_cyc, sw_len[i] + 4);
            check_eq($sformatf("sweep%0d_msb_err", i), msb_err, 0);
            check_eq($sformatf("sweep%0d_idx_err", i), idx_err, 0);
        end

        // Filter/volume loop, fil=3 vol=2.
        do_run(1'b0, 2'd0, 1, 3, 2, 1'b0, 1'b0, 2'd0, 1, 3, 2, 1'b0, 0, 0, 0);
        check_eq("loop_act_load", act_cnt, 2);
        check_eq("loop_act_err", act_err, 0);
        check_eq("loop_wei_load", wei_cnt, 6);
        check_eq("loop_acc_clr", clr_cnt, 6);
        check_eq("loop_update_out", upd_out_cnt, 6);
        check_eq("loop_update_in", upd_in_cnt, 1);
        check_eq("loop_done", done_cnt, 1);
        check_eq("loop_total", busy_cyc, 68);

        // 5-cycle stall in mid-COMPUTE.
        do_run(1'b0, 2'd0, 2, 1, 1, 1'b0, 1'b0, 2'd0, 2, 1, 1, 1'b0, 5, 5, 0);
        check_eq("stall_total", busy_cyc, 26);
        check_eq("stall_acc_cnt", acc_cnt, 16);
        check_eq("stall_strobes", stall_err, 0);
        check_eq("stall_idx_err", idx_err, 0);
        check_eq("stall_done", done_cyc, 26);

        // Zero cfg treated as 1; start held and cfg scrambled while busy.
        do_run(1'b0, 2'd0, 0, 0, 0, 1'b0, 1'b1, 2'd2, 5, 3, 4, 1'b0, 0, 0, 1);
        check_eq("zero_total", busy_cyc, 12);
        check_eq("zero_acc_cnt", acc_cnt, 8);
        check_eq("zero_done", done_cnt, 1);
        check_eq("zero_idx_err", idx_err, 0);

        // Continuous mode: second run picks up Pa=8 from the live cfg.
        do_run(1'b0, 2'd0, 1, 1, 1, 1'b1, 1'b1, 2'd0, 1, 1, 1, 1'b0, 0, 0, 0);
        check_eq("cont_first_done", done_cyc > 0 ? 12 : 0, 12);
        check_eq("cont_load_after_done", load_after_done, 1);
        check_eq("cont_done_cnt", done_cnt, 2);
        check_eq("cont_acc_cnt", acc_cnt, 24);
        check_eq("cont_total", busy_cyc, 32);
        check_eq("cont_idx_err", idx_err, 0);

        // Reset mid-COMPUTE, with start and stall also asserted.
        @(posedge clk); #1;
        start = 1'b1; cfg_pa_sel = 1'b0; cfg_pw_sel = 2'd0; cfg_num_ops = OPW'(2);
        cfg_num_fil = FILW'(1); cfg_num_vol = VOLW'(1); cfg_cont = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check_eq("prereset_acc_en", int'(acc_en), 1);
        rst = 1'b1; start = 1'b1; stall = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; stall = 1'b0;
        @(negedge clk);
        check_eq("midrun_reset_outputs", int'(all_out), 0);
        n = 0;
        repeat (30) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (done || busy) n++;
        end
        check_eq("reset_abort_quiet", n, 0);

        do_run(1'b0, 2'd0, 2, 1, 1, 1'b0, 1'b0, 2'd0, 2, 1, 1, 1'b0, 0, 0, 0);
        check_eq("rerun_acc_cnt", acc_cnt, 16);
        check_eq("rerun_done", done_cyc, 21);
        check_eq("rerun_total", busy_cyc, 21);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
